// File: rtl/dcache_nway_pkg.sv
// Shared types and helpers for the parametrised write-back data cache.
// Width helpers derive the address field split from the cache geometry.
package dcache_nway_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WB,
        REFILL,
        RESP,
        UC
    } state_t;

    function automatic int calc_off_w(input int line_words);
        return $clog2(line_words) + 2;
    endfunction

    function automatic int calc_idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int calc_tag_w(input int sets, input int line_words);
        return 32 - calc_idx_w(sets) - calc_off_w(line_words);
    endfunction

    function automatic logic [31:0] byte_merge(input logic [31:0] word,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  wen);
        logic [31:0] r;
        r = word;
        for (int unsigned b = 0; b < 4; b++) begin
            if (wen[b]) r[8*b +: 8] = wdata[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/dcache_nway_way.sv
// One cache way: valid/dirty/tag/data per set, combinational read at idx,
// full-line install or single-word update at the same idx.
module dcache_nway_way
    import dcache_nway_pkg::*;
#(
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 8,
    parameter int TAG_W      = 21
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [calc_idx_w(SETS)-1:0]       idx,
    input  logic                              we_line,
    input  logic                              we_word,
    input  logic [TAG_W-1:0]                  wr_tag,
    input  logic [32*LINE_WORDS-1:0]          wr_line,
    input  logic                              wr_dirty,
    input  logic [$clog2(LINE_WORDS)-1:0]     wr_sel,
    input  logic [31:0]                       wr_word,
    output logic                              rd_valid,
    output logic                              rd_dirty,
    output logic [TAG_W-1:0]                  rd_tag,
    output logic [32*LINE_WORDS-1:0]          rd_line
);

    logic [SETS-1:0]             valid_bits;
    logic [SETS-1:0]             dirty_bits;
    logic [TAG_W-1:0]            tag_mem  [SETS];
    logic [32*LINE_WORDS-1:0]    data_mem [SETS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_bits <= '0;
            dirty_bits <= '0;
        end else if (we_line) begin
            valid_bits[idx] <= 1'b1;
            dirty_bits[idx] <= wr_dirty;
        end else if (we_word) begin
            dirty_bits[idx] <= 1'b1;
        end
    end

    // Tag and data need no reset: they are only consulted behind a valid bit.
    always_ff @(posedge clk) begin
        if (we_line) begin
            tag_mem[idx]  <= wr_tag;
            data_mem[idx] <= wr_line;
        end else if (we_word) begin
            data_mem[idx][{wr_sel, 5'd0} +: 32] <= wr_word;
        end
    end

    assign rd_valid = valid_bits[idx];
    assign rd_dirty = dirty_bits[idx];
    assign rd_tag   = tag_mem[idx];
    assign rd_line  = data_mem[idx];

endmodule

// File: rtl/dcache_nway.sv
// Blocking write-back / write-allocate N-way data cache with round-robin
// replacement and an uncached bypass, speaking the rend/wend line handshake.
module dcache_nway
    import dcache_nway_pkg::*;
#(
    parameter int WAYS       = 2,
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      dc_bus_en_i,
    input  logic [3:0]                dc_bus_wen_i,
    input  logic [31:0]               dc_bus_phyaddr_i,
    input  logic [31:0]               dc_bus_wdata_i,
    input  logic                      cpu_cached_i,
    input  logic                      cpu_bus_stall_i,
    input  logic                      rend,
    input  logic                      wend,
    input  logic [32*LINE_WORDS-1:0]  cacheline_rdata_i,
    input  logic [31:0]               dc_uc_data_i,
    output logic                      cache_rreq,
    output logic                      cache_wreq,
    output logic                      uncache_rreq,
    output logic                      uncache_wreq,
    output logic [31:0]               dc_bus_addr_o,
    output logic [3:0]                dc_bus_wen_o,
    output logic [31:0]               dc_bus_wdata_o,
    output logic [32*LINE_WORDS-1:0]  cacheline_wdata_o,
    output logic                      dcache_stall_o,
    output logic [31:0]               dcache_rdata_o,
    output logic                      dcache_data_valid
);

    localparam int OFF_W  = calc_off_w(LINE_WORDS);
    localparam int IDX_W  = calc_idx_w(SETS);
    localparam int TAG_W  = calc_tag_w(SETS, LINE_WORDS);
    localparam int LINE_W = 32 * LINE_WORDS;
    localparam int WSEL_W = $clog2(LINE_WORDS);
    localparam int WAY_W  = $clog2(WAYS);

    state_t            state, state_nxt;
    logic [31:0]       req_addr, req_wdata;
    logic [3:0]        req_wen;
    logic [WAY_W-1:0]  victim_way, rr_ptr;
    logic              victim_rr;

    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [WSEL_W-1:0] req_sel;
    logic              req_store;

    assign req_idx   = req_addr[OFF_W +: IDX_W];
    assign req_tag   = req_addr[31 -: TAG_W];
    assign req_sel   = req_addr[2 +: WSEL_W];
    assign req_store = |req_wen;

    logic [WAYS-1:0]   way_valid, way_dirty, way_we_line, way_we_word;
    logic [TAG_W-1:0]  way_tag  [WAYS];
    logic [LINE_W-1:0] way_line [WAYS];
    logic [LINE_W-1:0] wr_line;
    logic [31:0]       wr_word;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        dcache_nway_way #(
            .SETS       (SETS),
            .LINE_WORDS (LINE_WORDS),
            .TAG_W      (TAG_W)
        ) u_way (
            .clk      (clk),
            .rst_n    (rst_n),
            .idx      (req_idx),
            .we_line  (way_we_line[w]),
            .we_word  (way_we_word[w]),
            .wr_tag   (req_tag),
            .wr_line  (wr_line),
            .wr_dirty (req_store),
            .wr_sel   (req_sel),
            .wr_word  (wr_word),
            .rd_valid (way_valid[w]),
            .rd_dirty (way_dirty[w]),
            .rd_tag   (way_tag[w]),
            .rd_line  (way_line[w])
        );
    end

    logic             hit, any_inv, vic_rr;
    logic [WAY_W-1:0] hit_way, inv_way, vic_way;
    logic [31:0]      hit_word, vic_word;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        any_inv = 1'b0;
        inv_way = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (way_valid[w] && way_tag[w] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!way_valid[w] && !any_inv) begin
                any_inv = 1'b1;
                inv_way = WAY_W'(w);
            end
        end
        vic_way = any_inv ? inv_way : rr_ptr;
        vic_rr  = !any_inv;
    end

    assign hit_word = way_line[hit_way][{req_sel, 5'd0} +: 32];
    assign vic_word = way_line[victim_way][{req_sel, 5'd0} +: 32];

    // A load has wen=0, so the merge leaves refill data untouched.
    always_comb begin
        wr_word = byte_merge(hit_word, req_wdata, req_wen);
        wr_line = cacheline_rdata_i;
        wr_line[{req_sel, 5'd0} +: 32] =
            byte_merge(cacheline_rdata_i[{req_sel, 5'd0} +: 32], req_wdata, req_wen);
    end

    always_comb begin
        state_nxt         = state;
        cache_rreq        = 1'b0;
        cache_wreq        = 1'b0;
        uncache_rreq      = 1'b0;
        uncache_wreq      = 1'b0;
        dc_bus_addr_o     = '0;
        dc_bus_wen_o      = '0;
        dc_bus_wdata_o    = '0;
        cacheline_wdata_o = '0;
        dcache_stall_o    = 1'b0;
        dcache_rdata_o    = '0;
        dcache_data_valid = 1'b0;
        way_we_line       = '0;
        way_we_word       = '0;
        unique case (state)
            IDLE: begin
                if (dc_bus_en_i && !cpu_bus_stall_i) state_nxt = cpu_cached_i ? LOOKUP : UC;
            end
            LOOKUP: begin
                if (hit) begin
                    if (req_store) begin
                        way_we_word[hit_way] = 1'b1;
                    end else begin
                        dcache_rdata_o    = hit_word;
                        dcache_data_valid = 1'b1;
                    end
                    state_nxt = IDLE;
                end else begin
                    dcache_stall_o = 1'b1;
                    state_nxt = (way_valid[vic_way] && way_dirty[vic_way]) ? WB : REFILL;
                end
            end
            WB: begin
                cache_wreq        = !wend;
                dc_bus_addr_o     = {way_tag[victim_way], req_idx, {OFF_W{1'b0}}};
                cacheline_wdata_o = way_line[victim_way];
                dcache_stall_o    = 1'b1;
                if (wend) state_nxt = REFILL;
            end
            REFILL: begin
                cache_rreq     = !rend;
                dc_bus_addr_o  = {req_addr[31:OFF_W], {OFF_W{1'b0}}};
                dcache_stall_o = 1'b1;
                if (rend) begin
                    way_we_line[victim_way] = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (!req_store) begin
                    dcache_rdata_o    = vic_word;
                    dcache_data_valid = 1'b1;
                end
                state_nxt = IDLE;
            end
            UC: begin
                dc_bus_addr_o = req_addr;
                if (req_store) begin
                    uncache_wreq   = !wend;
                    dc_bus_wen_o   = req_wen;
                    dc_bus_wdata_o = req_wdata;
                    dcache_stall_o = !wend;
                    if (wend) state_nxt = IDLE;
                end else begin
                    uncache_rreq   = !rend;
                    dcache_stall_o = !rend;
                    if (rend) begin
                        dcache_rdata_o    = dc_uc_data_i;
                        dcache_data_valid = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Cacheability is carried by the IDLE->LOOKUP/UC choice, not a separate flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_addr   <= '0;
            req_wen    <= '0;
            req_wdata  <= '0;
            victim_way <= '0;
            victim_rr  <= 1'b0;
            rr_ptr     <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && dc_bus_en_i && !cpu_bus_stall_i) begin
                req_addr  <= dc_bus_phyaddr_i;
                req_wen   <= dc_bus_wen_i;
                req_wdata <= dc_bus_wdata_i;
            end
            if (state == LOOKUP && !hit) begin
                victim_way <= vic_way;
                victim_rr  <= vic_rr;
            end
            if (state == REFILL && rend && victim_rr) rr_ptr <= rr_ptr + 1'b1;
        end
    end

endmodule

// File: tb/tb_dcache_nway.sv
// Directed bench for dcache_nway (2 ways, 64 sets, 8-word lines) checked
// every cycle against a transaction-level cache model.
module tb_dcache_nway;

    localparam int WAYS = 2;
    localparam int SETS = 64;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0, cached = 1'b0, cpu_stall = 1'b0, rend = 1'b0, wend = 1'b0;
    logic [3:0]   wen = '0;
    logic [31:0]  addr = '0, wdata = '0, ucd = '0;
    logic [255:0] rline = '0;

    logic         cache_rreq, cache_wreq, uncache_rreq, uncache_wreq;
    logic [31:0]  dc_bus_addr_o, dc_bus_wdata_o, dcache_rdata_o;
    logic [3:0]   dc_bus_wen_o;
    logic [255:0] cacheline_wdata_o;
    logic         dcache_stall_o, dcache_data_valid;

    always #5 clk = ~clk;

    dcache_nway #(.WAYS(WAYS), .SETS(SETS), .LINE_WORDS(8)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .dc_bus_en_i       (en),
        .dc_bus_wen_i      (wen),
        .dc_bus_phyaddr_i  (addr),
        .dc_bus_wdata_i    (wdata),
        .cpu_cached_i      (cached),
        .cpu_bus_stall_i   (cpu_stall),
        .rend              (rend),
        .wend              (wend),
        .cacheline_rdata_i (rline),
        .dc_uc_data_i      (ucd),
        .cache_rreq        (cache_rreq),
        .cache_wreq        (cache_wreq),
        .uncache_rreq      (uncache_rreq),
        .uncache_wreq      (uncache_wreq),
        .dc_bus_addr_o     (dc_bus_addr_o),
        .dc_bus_wen_o      (dc_bus_wen_o),
        .dc_bus_wdata_o    (dc_bus_wdata_o),
        .cacheline_wdata_o (cacheline_wdata_o),
        .dcache_stall_o    (dcache_stall_o),
        .dcache_rdata_o    (dcache_rdata_o),
        .dcache_data_valid (dcache_data_valid)
    );

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;

    logic         e_rreq = 0, e_wreq = 0, e_urreq = 0, e_uwreq = 0, e_stall = 0, e_valid = 0;
    logic [31:0]  e_addr = '0, e_wdata = '0, e_rdata = '0;
    logic [3:0]   e_wen = '0;
    logic [255:0] e_line = '0;

    task automatic cmp(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("cache_rreq",   256'(cache_rreq),        256'(e_rreq));
            cmp("cache_wreq",   256'(cache_wreq),        256'(e_wreq));
            cmp("uncache_rreq", 256'(uncache_rreq),      256'(e_urreq));
            cmp("uncache_wreq", 256'(uncache_wreq),      256'(e_uwreq));
            cmp("bus_addr",     256'(dc_bus_addr_o),     256'(e_addr));
            cmp("bus_wen",      256'(dc_bus_wen_o),      256'(e_wen));
            cmp("bus_wdata",    256'(dc_bus_wdata_o),    256'(e_wdata));
            cmp("line_wdata",   cacheline_wdata_o,       e_line);
            cmp("stall",        256'(dcache_stall_o),    256'(e_stall));
            cmp("data_valid",   256'(dcache_data_valid), 256'(e_valid));
            cmp("rdata",        256'(dcache_rdata_o),    256'(e_rdata));
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog t=%0t got=running want=finished", $time);
        $fatal(1, "watchdog");
    end

    // Cache model: contents per way/set plus the round-robin pointer.
    logic         m_valid [WAYS][SETS];
    logic         m_dirty [WAYS][SETS];
    logic [20:0]  m_tag   [WAYS][SETS];
    logic [255:0] m_line  [WAYS][SETS];
    int           m_rr;

    task automatic model_clear();
        for (int w = 0; w < WAYS; w++)
            for (int s = 0; s < SETS; s++) begin
                m_valid[w][s] = 1'b0;
                m_dirty[w][s] = 1'b0;
            end
        m_rr = 0;
    endtask

    function automatic logic [31:0] bmerge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    function automatic logic [255:0] gen_line(input logic [31:0] seed);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = seed + 32'(i) * 32'h0101_0101;
        return l;
    endfunction

    task automatic zero_exp();
        e_rreq = 0; e_wreq = 0; e_urreq = 0; e_uwreq = 0; e_stall = 0; e_valid = 0;
        e_addr = '0; e_wdata = '0; e_rdata = '0; e_wen = '0; e_line = '0;
    endtask

    int           cyc_no;
    int           cap_valid, cap_lat, cap_stall;
    logic         cap_rreq, cap_wreq, cap_urreq;
    logic [31:0]  cap_rdata, cap_raddr, cap_waddr;
    logic [255:0] cap_wline;

    task automatic step();
        @(posedge clk);
        #1;
        cyc_no++;
    endtask

    task automatic sample();
        #1;
        if (dcache_data_valid) begin cap_valid++; cap_rdata = dcache_rdata_o; cap_lat = cyc_no; end
        if (cache_rreq) begin cap_rreq = 1; cap_raddr = dc_bus_addr_o; end
        if (cache_wreq) begin cap_wreq = 1; cap_waddr = dc_bus_addr_o; cap_wline = cacheline_wdata_o; end
        if (uncache_rreq) cap_urreq = 1;
        if (dcache_stall_o) cap_stall++;
    endtask

    task automatic access(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd,
                          input logic c, input int lat_wait, input logic [255:0] line_in,
                          input logic [31:0] uc_word);
        int s, tg, sel, hw, nh, vw;
        logic by_rr;
        logic [255:0] nl;
        cap_valid = 0; cap_lat = -1; cap_stall = 0;
        cap_rreq = 0; cap_wreq = 0; cap_urreq = 0;
        cap_rdata = '0; cap_raddr = '0; cap_waddr = '0; cap_wline = '0;
        s   = int'(a[10:5]);
        tg  = int'(a[31:11]);
        sel = int'(a[4:2]);
        // accept cycle; stray handshakes in IDLE must be ignored
        step(); zero_exp();
        en = 1; cpu_stall = 0; wen = we; addr = a; wdata = wd; cached = c; rend = 1; wend = 1;
        sample();
        cyc_no = 0;
        step(); zero_exp();
        en = 0; wen = '0; addr = '0; wdata = '0; cached = 0; rend = 0; wend = 0;
        if (c) begin
            hw = -1; nh = 0;
            for (int w = 0; w < WAYS; w++)
                if (m_valid[w][s] && m_tag[w][s] == 21'(tg)) begin hw = w; nh++; end
            if (nh > 1) $fatal(1, "FAIL multi_hit set=%0d got=%0d want=1", s, nh);
            if (hw >= 0) begin
                if (we == 4'b0) begin
                    e_rdata = m_line[hw][s][32*sel +: 32];
                    e_valid = 1;
                end else begin
                    m_line[hw][s][32*sel +: 32] = bmerge(m_line[hw][s][32*sel +: 32], wd, we);
                    m_dirty[hw][s] = 1'b1;
                end
                sample();
            end else begin
                vw = -1;
                for (int w = 0; w < WAYS; w++) if (!m_valid[w][s] && vw < 0) vw = w;
                by_rr = (vw < 0);
                if (by_rr) vw = m_rr;
                e_stall = 1;
                sample();
                if (m_valid[vw][s] && m_dirty[vw][s]) begin
                    for (int k = 0; k <= lat_wait; k++) begin
                        step(); zero_exp();
                        wend = (k == lat_wait); rend = !wend;
                        e_wreq = !wend; e_stall = 1;
                        e_addr = {m_tag[vw][s], 6'(s), 5'd0};
                        e_line = m_line[vw][s];
                        sample();
                    end
                end
                for (int k = 0; k <= lat_wait; k++) begin
                    step(); zero_exp();
                    rend = (k == lat_wait); wend = !rend;
                    rline = rend ? line_in : ~line_in;
                    e_rreq = !rend; e_stall = 1;
                    e_addr = {a[31:5], 5'd0};
                    sample();
                end
                nl = line_in;
                nl[32*sel +: 32] = bmerge(nl[32*sel +: 32], wd, we);
                m_line[vw][s] = nl; m_tag[vw][s] = 21'(tg);
                m_valid[vw][s] = 1'b1; m_dirty[vw][s] = (we != 4'b0);
                if (by_rr) m_rr = (m_rr + 1) % WAYS;
                step(); zero_exp();
                rend = 0; wend = 0; rline = '0;
                if (we == 4'b0) begin e_rdata = nl[32*sel +: 32]; e_valid = 1; end
                sample();
            end
        end else begin
            for (int k = 0; k <= lat_wait; k++) begin
                if (k > 0) begin step(); zero_exp(); end
                e_addr = a;
                if (we == 4'b0) begin
                    rend = (k == lat_wait); wend = !rend;
                    ucd = rend ? uc_word : 32'hFFFF_FFFF;
                    e_urreq = !rend; e_stall = !rend;
                    if (rend) begin e_rdata = uc_word; e_valid = 1; end
                end else begin
                    wend = (k == lat_wait); rend = !wend;
                    e_uwreq = !wend; e_stall = !wend; e_wen = we; e_wdata = wd;
                end
                sample();
            end
        end
    endtask

    logic [255:0] line1;

    initial begin
        model_clear();
        zero_exp();
        chk_en = 1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        cmp("reset_stall", 256'(dcache_stall_o), 256'(0));

        // cold load, refill, response
        line1 = gen_line(32'h0000_1000);
        line1[63:32] = 32'hDEAD_BEEF;
        access(32'h0000_1004, 4'b0000, '0, 1, 2, line1, '0);
        cmp("cold_rreq_seen", 256'(cap_rreq),  256'(1));
        cmp("cold_raddr",     256'(cap_raddr), 256'(32'h0000_1000));
        cmp("cold_rdata",     256'(cap_rdata), 256'(32'hDEAD_BEEF));
        cmp("cold_vcount",    256'(cap_valid), 256'(1));

        // held off by pipeline stall, then a hit one cycle after accept
        step(); zero_exp(); en = 1; cpu_stall = 1; addr = 32'h0000_1004; cached = 1;
        access(32'h0000_1004, 4'b0000, '0, 1, 0, '0, '0);
        cmp("hit_no_rreq", 256'(cap_rreq),  256'(0));
        cmp("hit_latency", 256'(cap_lat),   256'(1));
        cmp("hit_rdata",   256'(cap_rdata), 256'(32'hDEAD_BEEF));

        // store hit then readback
        access(32'h0000_1004, 4'b0011, 32'h1234_5678, 1, 0, '0, '0);
        access(32'h0000_1004, 4'b0000, '0, 1, 0, '0, '0);
        cmp("merge_rdata", 256'(cap_rdata), 256'(32'hDEAD_5678));

        // fill set 0, evict the dirty way, then round-robin moves on
        access(32'h0000_2000, 4'b0000, '0, 1, 1, gen_line(32'h0000_2000), '0);
        access(32'h0000_3000, 4'b0000, '0, 1, 2, gen_line(32'h0000_3000), '0);
        cmp("wb_seen",  256'(cap_wreq),         256'(1));
        cmp("wb_addr",  256'(cap_waddr),        256'(32'h0000_1000));
        cmp("wb_word1", 256'(cap_wline[63:32]), 256'(32'hDEAD_5678));
        cmp("wb_raddr", 256'(cap_raddr),        256'(32'h0000_3000));
        access(32'h0000_4000, 4'b0000, '0, 1, 0, gen_line(32'h0000_4000), '0);
        cmp("rr_clean_no_wb", 256'(cap_wreq), 256'(0));
        access(32'h0000_3004, 4'b0000, '0, 1, 0, '0, '0);
        cmp("rr_keep_hit", 256'(cap_lat), 256'(1));
        access(32'h0000_2008, 4'b0000, '0, 1, 1, gen_line(32'h0000_2000), '0);
        cmp("rr_evicted_miss", 256'(cap_rreq), 256'(1));

        // store miss merges into refilled line
        access(32'h0000_0124, 4'b1100, 32'hAABB_CCDD, 1, 1, gen_line(32'h0000_0100), '0);
        access(32'h0000_0124, 4'b0000, '0, 1, 0, '0, '0);
        cmp("stmiss_rdata", 256'(cap_rdata), 256'(32'hAABB_0201));

        // uncached load, then same address cached still misses
        access(32'hBFAF_8000, 4'b0000, '0, 0, 2, '0, 32'h0000_00A5);
        cmp("uc_rreq_seen", 256'(cap_urreq), 256'(1));
        cmp("uc_rdata",     256'(cap_rdata), 256'(32'h0000_00A5));
        cmp("uc_no_line",   256'(cap_rreq),  256'(0));
        access(32'hBFAF_8000, 4'b0000, '0, 1, 1, gen_line(32'hBFAF_8000), '0);
        cmp("uc_then_miss", 256'(cap_rreq), 256'(1));

        // uncached store held across 3 stall cycles
        access(32'hBFAF_8010, 4'b1000, 32'h5A00_0000, 0, 3, '0, '0);
        cmp("ucst_stalls", 256'(cap_stall), 256'(3));

        // reset in the middle of a refill
        step(); zero_exp(); en = 1; addr = 32'h0000_5000; cached = 1; rend = 0; wend = 0;
        step(); zero_exp(); en = 0; addr = '0; cached = 0; e_stall = 1;
        step(); zero_exp(); e_rreq = 1; e_addr = 32'h0000_5000; e_stall = 1;
        #1 cmp("pre_rst_rreq", 256'(cache_rreq), 256'(1));
        #1 rst_n = 0; zero_exp(); model_clear();
        #1 cmp("rst_rreq",  256'(cache_rreq),     256'(0));
        cmp("rst_stall",    256'(dcache_stall_o), 256'(0));
        cmp("rst_addr",     256'(dc_bus_addr_o),  256'(0));
        @(posedge clk); #1 rst_n = 1;
        access(32'h0000_0124, 4'b0000, '0, 1, 1, gen_line(32'h0000_7700), '0);
        cmp("post_rst_miss",  256'(cap_rreq),  256'(1));
        cmp("post_rst_rdata", 256'(cap_rdata), 256'(32'h0101_7801));

        step(); zero_exp(); rend = 0; wend = 0;
        step();
        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dcache_nway.md
Name: dcache_nway

Overview:
- Parametrised blocking write-back, write-allocate data cache; successor to the fixed 2-way dcache.
- Generalised in associativity, set count and line length; round-robin replacement.
- Uncached bypass path.
- Sits between the CPU memory stage and cache_axi, using the same rend/wend line handshake.

Parameters:
- WAYS, 2: associativity; power of 2, range 2..8.
- SETS, 64: sets per way; power of 2.
- LINE_WORDS, 8: 32-bit words per line; power of 2, range 2..16.
- Derived: OFF_W = log2(LINE_WORDS)+2, IDX_W = log2(SETS), TAG_W = 32-IDX_W-OFF_W, LINE_W = 32*LINE_WORDS.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- dc_bus_en_i  in  1  request valid
- dc_bus_wen_i  in  4  byte write enables; 0 means load
- dc_bus_phyaddr_i  in  32  physical address
- dc_bus_wdata_i  in  32  store data
- cpu_cached_i  in  1  1 = cacheable
- cpu_bus_stall_i  in  1  pipeline stall; blocks acceptance
- rend  in  1  read done; refill line or uncached word valid this cycle
- wend  in  1  write done
- cacheline_rdata_i  in  LINE_W  refill line
- dc_uc_data_i  in  32  uncached read word
- cache_rreq  out  1  line refill request
- cache_wreq  out  1  line writeback request
- uncache_rreq  out  1  uncached read request
- uncache_wreq  out  1  uncached write request
- dc_bus_addr_o  out  32  request address
- dc_bus_wen_o  out  4  uncached byte enables
- dc_bus_wdata_o  out  32  uncached store data
- cacheline_wdata_o  out  LINE_W  victim line
- dcache_stall_o  out  1  stall CPU
- dcache_rdata_o  out  32  load data
- dcache_data_valid  out  1  load data valid pulse

Behaviour:
- Reset: all outputs 0, FSM IDLE, all valid/dirty bits 0, round-robin counter 0. Asserting reset mid-operation abandons any AXI transaction with no drain.
- Storage: tag, valid and dirty bits and data held in flops per way/set. Reads are combinational from the latched request.
- FSM states: IDLE, LOOKUP, WB, REFILL, RESP, UC.
- IDLE:
  - Accept when dc_bus_en_i=1 and cpu_bus_stall_i=0.
  - Latch addr, wen, wdata and cached.
  - Go to LOOKUP if cached, else UC.
- LOOKUP:
  - Hit = valid && tag match in any way. More than one matching way is illegal; the bench asserts against it.
  - Load hit: dcache_rdata_o = selected word, dcache_data_valid=1, stall=0, next IDLE. Latency is 1 cycle after accept.
  - Store hit: byte-merge wdata by wen into the word, set dirty, stall=0, next IDLE.
  - Miss, victim selection: lowest-index invalid way, else rr_ptr.
  - Miss, next state: WB if the victim is valid and dirty, else REFILL. stall=1.
- WB:
  - cache_wreq=1, dc_bus_addr_o = {victim tag, idx, 0}, cacheline_wdata_o = victim line.
  - Requests stay held until wend. On wend: requests drop the same cycle, next REFILL.
- REFILL:
  - cache_rreq=1, dc_bus_addr_o = line-aligned request address; held until rend.
  - On rend: install the line with valid=1 and tag.
  - A store merges bytes into the installed line and sets dirty=1; a load clears dirty.
  - rr_ptr increments modulo WAYS only if the victim was chosen by rr_ptr.
  - Next RESP.
- RESP: load drives data from the array with valid=1. stall=0, next IDLE.
- UC:
  - Load: uncache_rreq=1 until rend. On rend: dcache_rdata_o = dc_uc_data_i, valid=1, stall=0, next IDLE.
  - Store: uncache_wreq=1 with wen and wdata until wend, then next IDLE.
  - Uncached accesses never touch the arrays.
- dcache_stall_o = 1 in WB, REFILL and UC except on the completing cycle; 1 in LOOKUP on miss.
- rend/wend arriving outside the matching state are ignored.
- A new request is accepted only in IDLE: no hit-under-miss, no back-to-back acceptance from LOOKUP.

Decomposition:
- Package dcache_nway_pkg:
  - State enum.
  - Derived width functions (clog2-based).
  - Function byte_merge(word, wdata, wen).
- Sub-module dcache_nway_way: one way's tag/valid/dirty/data arrays with read port and line/word write port, instantiated WAYS times by generate.

Test Plan:
- Reset, then cached load 0x0000_1004 with cold cache -> cache_rreq with addr 0x0000_1000. rend with word1 = 0xDEADBEEF -> RESP: rdata 0xDEADBEEF, valid pulse. Reload of the same address -> LOOKUP hit, valid 1 cycle after accept, no request.
- Store wen=4'b0011, wdata 0x1234_5678 to the hit line -> next load reads 0xDEAD5678. Dirty set.
- WAYS=2: fill both ways of set 0 (one dirty), then a third tag to set 0 -> cache_wreq with the dirty victim line and its address. wend -> cache_rreq. rr_ptr advances 0->1.
- Uncached load 0xBFAF_8000 -> uncache_rreq until rend. rdata = dc_uc_data_i 0x0000_00A5. A second access still misses, so the arrays are unchanged.
- Uncached store wen=4'b1000 -> uncache_wreq, wen/wdata held steady across 3 stall cycles until wend.
- Reset asserted during REFILL -> outputs 0 immediately. Previously valid lines are invalid, so a subsequent load misses.
